// File: rtl/tinyalu_core_if.sv
// Command/result bus between a requester and tinyalu_core.
// The requester holds start high until it samples done.
interface tinyalu_core_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    modport master (output A, B, op, start, input done, result);
    modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu_core.sv
// tinyalu_core: 8-bit add/and/xor/mul ALU with a start/done handshake.
// Define TINYALU_MUL_EN to build the multi-cycle multiplier; otherwise mul returns 0 in one cycle.
module tinyalu_core #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic          clk,
    input  logic          reset,
    tinyalu_core_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    if (MUL_LATENCY < 2 || MUL_LATENCY > 8) begin : g_bad_latency
        $error("tinyalu_core: MUL_LATENCY must be within 2..8");
    end

`ifdef TINYALU_MUL_EN
    localparam int unsigned CNT_W = 3;
    typedef enum logic [1:0] {IDLE, BUSY, DONE, WAIT_LOW} state_e;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [CNT_W-1:0] cnt_q;
`else
    typedef enum logic [1:0] {IDLE, DONE, WAIT_LOW} state_e;
`endif

    state_e      state_q;
    logic        done_q;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        accept;

    assign accept = bus.start && (bus.op inside {OP_ADD, OP_AND, OP_XOR, OP_MUL});

    // Single-cycle result; mul falls to zero here and is produced from the latched operands instead.
    always_comb begin
        result_d = '0;
        case (bus.op)
            OP_ADD:  result_d = 16'(bus.A) + 16'(bus.B);
            OP_AND:  result_d = {8'h00, bus.A & bus.B};
            OP_XOR:  result_d = {8'h00, bus.A ^ bus.B};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef TINYALU_MUL_EN
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
`ifdef TINYALU_MUL_EN
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        cnt_q <= '0;
                        if (bus.op == OP_MUL) begin
                            state_q <= BUSY;
                        end else begin
                            result_q <= result_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
`else
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
`endif
                    end
                end
`ifdef TINYALU_MUL_EN
                // Dropping start aborts; done lands MUL_LATENCY cycles after acceptance.
                BUSY: begin
                    if (!bus.start) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(MUL_LATENCY - 2)) begin
                        result_q <= 16'(a_q) * 16'(b_q);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                DONE:     state_q <= bus.start ? WAIT_LOW : IDLE;
                WAIT_LOW: if (!bus.start) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_tinyalu_core.sv
// Directed self-checking bench for tinyalu_core with a result scoreboard.
// Expectations follow TINYALU_MUL_EN the same way the design build does.
module tb_tinyalu_core;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] sb[$];

    tinyalu_core_if dut_if();

    tinyalu_core #(.MUL_LATENCY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        dut_if.start = s;
        dut_if.op    = o;
        dut_if.A     = a;
        dut_if.B     = b;
    endtask

    task automatic check(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample on the falling edge, and score done/result.
    task automatic step(input logic exp_done, input string tag);
        logic [15:0] exp_r;
        @(posedge clk);
        @(negedge clk);
        check(16'(dut_if.done), 16'(exp_done), {tag, "_done"});
        if (exp_done) begin
            exp_r = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            check(dut_if.result, exp_r, {tag, "_result"});
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        #12;
        check(16'(dut_if.done), 16'h0000, "reset_done");
        check(dut_if.result, 16'h0000, "reset_result");
        @(negedge clk);
        reset = 1'b0;

        // Add with carry into bit 8, start held past done
        drive(1'b1, 3'b001, 8'hFF, 8'h01);
        sb.push_back(16'h0100);
        step(1'b1, "add_ff_01");
        step(1'b0, "add_held");
        step(1'b0, "add_wait_low");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "add_release");
        check(dut_if.result, 16'h0100, "add_hold");

        // Multiply; inputs change while in flight
        drive(1'b1, 3'b100, 8'hFF, 8'hFF);
`ifdef TINYALU_MUL_EN
        sb.push_back(16'hFE01);
        step(1'b0, "mul_c1");
        drive(1'b1, 3'b001, 8'h12, 8'h34);
        step(1'b0, "mul_c2");
        step(1'b1, "mul_c3");
`else
        sb.push_back(16'h0000);
        step(1'b1, "mul_disabled");
`endif
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "mul_release");
        step(1'b0, "idle_gap");

        // Xor with start held for 10 cycles: exactly one done
        drive(1'b1, 3'b011, 8'hA5, 8'h0F);
        sb.push_back(16'h00AA);
        step(1'b1, "xor_a5_0f");
        for (int i = 0; i < 9; i++) step(1'b0, "xor_held");
        check(dut_if.result, 16'h00AA, "xor_hold");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "xor_release");
        drive(1'b1, 3'b011, 8'h3C, 8'hFF);
        sb.push_back(16'h00C3);
        step(1'b1, "xor_rearm");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "xor_rearm_release");

        drive(1'b1, 3'b010, 8'hF0, 8'h3C);
        sb.push_back(16'h0030);
        step(1'b1, "and_f0_3c");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "and_release");

        // no_op and illegal opcodes are ignored
        drive(1'b1, 3'b000, 8'h11, 8'h22);
        for (int i = 0; i < 5; i++) step(1'b0, "noop");
        drive(1'b1, 3'b110, 8'h11, 8'h22);
        for (int i = 0; i < 5; i++) step(1'b0, "illegal");
        check(dut_if.result, 16'h0030, "noop_result");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "noop_release");

`ifdef TINYALU_MUL_EN
        // Abort: start dropped during cycle 2 of the multiply
        drive(1'b1, 3'b100, 8'h02, 8'h03);
        step(1'b0, "abort_c1");
        step(1'b0, "abort_c2");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "abort_c3");
        step(1'b0, "abort_after");
        check(dut_if.result, 16'h0030, "abort_result");
`endif

        // Reset between edges during the multiply
        drive(1'b1, 3'b100, 8'h07, 8'h09);
`ifdef TINYALU_MUL_EN
        step(1'b0, "rst_mul_c1");
`else
        sb.push_back(16'h0000);
        step(1'b1, "rst_mul_c1");
`endif
        #1 reset = 1'b1;
        #1;
        check(16'(dut_if.done), 16'h0000, "rst_async_done");
        check(dut_if.result, 16'h0000, "rst_async_result");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, "rst_no_done");

        drive(1'b1, 3'b001, 8'h03, 8'h04);
        sb.push_back(16'h0007);
        step(1'b1, "add_after_reset");
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step(1'b0, "final_release");

        check(16'(sb.size()), 16'h0000, "sb_empty");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tinyalu_core.md
TINYALU_CORE -- requirements
Module: tinyalu_core

Interface
REQ-001 The block SHALL have parameter MUL_LATENCY, default 3, giving the number of cycles from multiply acceptance to done, with a legal range of 2..8.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 A  input  8  unsigned operand A.
REQ-005 B  input  8  unsigned operand B.
REQ-006 op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal.
REQ-007 start  input  1  command request, held high by the requester until it samples done.
REQ-008 done  output  1  registered one-cycle pulse marking a valid result.
REQ-009 result  output  16  registered result, valid while done=1.

Function
REQ-010 The block SHALL use the states IDLE, BUSY, DONE and WAIT_LOW.
REQ-011 In IDLE, the block SHALL accept a command at the rising edge where start=1 and op is in {add, and, xor, mul}, and SHALL latch A, B and op at that edge.
REQ-012 In IDLE, start=1 with no_op or an illegal op SHALL be ignored: no done, result unchanged, state stays IDLE.
REQ-013 For add, and and xor, done SHALL be 1 during the single cycle immediately following the acceptance edge (IDLE->DONE).
REQ-014 For mul, the block SHALL go IDLE->BUSY, and done SHALL be 1 during cycle MUL_LATENCY after the acceptance edge (BUSY->DONE).
REQ-015 In each cycle where done=1, result SHALL be: add = zero-extended 9-bit A+B; and = {8'h00, A&B}; xor = {8'h00, A^B}; mul = full 16-bit unsigned A*B.
REQ-016 result SHALL hold its value until the next done pulse; done SHALL never be high for two consecutive cycles.
REQ-017 From DONE, the block SHALL go to WAIT_LOW if start=1, otherwise to IDLE.
REQ-018 WAIT_LOW SHALL go to IDLE only after start is sampled 0, so a held start never causes a second command.
REQ-019 If start is sampled 0 while in BUSY, the operation SHALL abort: return to IDLE, no done pulse, result unchanged.
REQ-020 Changes on A, B or op after the acceptance edge SHALL NOT affect the in-flight result.
REQ-021 A new command SHALL be accepted no earlier than the edge after start is sampled low.

Reset
REQ-022 While reset=1, the block SHALL force state=IDLE, done=0, result=16'h0000 and clear the latched operands, independently of clk.
REQ-023 Reset asserted mid-operation SHALL discard the operation with no done pulse after deassertion.
REQ-024 The first command SHALL be accepted at the first rising edge after reset deasserts where the REQ-011 conditions hold.

Configuration
REQ-025 When macro TINYALU_MUL_EN is defined, mul SHALL behave per REQ-014 and REQ-015.
REQ-026 When TINYALU_MUL_EN is undefined, the block SHALL contain no multiplier or BUSY state, and mul SHALL complete like a single-cycle op (done one cycle after acceptance) with result=16'h0000.

Verification
REQ-027 Add: A=8'hFF, B=8'h01, op=001, start held -> done=1 one cycle after acceptance, result=16'h0100.
REQ-028 Mul (macro defined, MUL_LATENCY=3): A=8'hFF, B=8'hFF -> done only in cycle 3 after acceptance, result=16'hFE01; with macro undefined -> done after 1 cycle, result=16'h0000.
REQ-029 Held start: xor with A=8'hA5, B=8'h0F and start kept high for 10 cycles -> exactly one done pulse with result=16'h00AA, then none until start drops and rises again.
REQ-030 Abort and no_op: mul with start dropped in cycle 2 -> no done and result unchanged; start=1 with op=000 or op=110 for 5 cycles -> no done.
REQ-031 Reset mid-mul: reset asserted between clock edges in cycle 1 of BUSY -> done=0 and result=16'h0000 immediately, no later done; an add issued after reset (A=3, B=4) -> result=16'h0007.
